bcd_sub_serial: RTL

//   Digit-serial packed-BCD subtractor: z = x - y, one BCD digit per clock, LSD first.

---
 rtl/bcd_sub_serial_if.sv | 35 +++
 rtl/bcd_sub_serial.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial_if.sv
`default_nettype none
//============================================================================
// Module   : bcd_sub_serial_if
// Purpose  : Handshake/data bundle for the digit-serial packed-BCD subtractor.
//            The master drives start and the operands. The slave returns
//            busy/done and the held result (z, borrow, err).
// Ports    : start, x, y            (master -> slave)
//            busy, done, z, borrow, err (slave -> master)
// Revision : 1.0 - initial release
//============================================================================
interface bcd_sub_serial_if #(
    parameter int DIGITS = 4
);
    localparam int WIDTH = 4 * DIGITS;

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             borrow;
    logic             err;

    modport master (
        output start, x, y,
        input  busy, done, z, borrow, err
    );

    modport slave (
        input  start, x, y,
        output busy, done, z, borrow, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_sub_serial.sv
`default_nettype none
//============================================================================
// Module   : bcd_sub_serial
// Purpose  : Digit-serial packed-BCD subtractor, z = x - y. It processes one
//            BCD digit per clock, least significant digit first. Handshake is
//            start/busy/done. The result is held until the next completed
//            operation.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            bus.start  - request, sampled in IDLE or DONE only
//            bus.x/y    - minuend / subtrahend, packed BCD
//            bus.busy   - high while digits are processed
//            bus.done   - one-cycle pulse, result valid from this cycle on
//            bus.z      - difference (ten's complement when borrow=1)
//            bus.borrow - final borrow out of the MSD (x < y)
//            bus.err    - an operand digit was > 9; z/borrow forced to 0
// Revision : 1.0 - initial release
//============================================================================
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bcd_sub_serial_if.slave  bus
);
    localparam int WIDTH = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIGITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [WIDTH-1:0] r_res;
    logic             r_b;
    logic             r_err_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_borrow;
    logic             r_err;

    logic [3:0]       w_xd;
    logic [3:0]       w_yd;
    logic [4:0]       w_diff;
    logic             w_neg;
    logic [3:0]       w_digit;
    logic             w_b_next;
    logic             w_err_next;
    logic [WIDTH-1:0] w_res_next;

    // The current digits are always the LSDs of the operand shift registers.
    assign w_xd = r_xs[3:0];
    assign w_yd = r_ys[3:0];

    // With raw nibbles (0..15) and a borrow, xd - yd - b spans -16..15.
    // That range fits a 5-bit two's-complement value, so bit 4 is the sign.
    assign w_diff = {1'b0, w_xd} - {1'b0, w_yd} - {4'd0, r_b};
    assign w_neg  = w_diff[4];

    // For a negative difference, add 10 modulo 16 to restore the decimal
    // digit. Only the low nibble of d+10 is ever kept.
    assign w_digit    = w_neg ? (w_diff[3:0] + 4'd10) : w_diff[3:0];
    assign w_b_next   = w_neg;
    assign w_err_next = r_err_acc | (w_xd > 4'd9) | (w_yd > 4'd9);

    // Each new digit enters at the top of the result register. After DIGITS
    // shifts, the first digit processed (the LSD) sits at bits [3:0].
    generate
        if (DIGITS > 1) begin : g_res_wide
            assign w_res_next = {w_digit, r_res[WIDTH-1:4]};
        end else begin : g_res_single
            assign w_res_next = w_digit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_xs      <= '0;
            r_ys      <= '0;
            r_res     <= '0;
            r_b       <= 1'b0;
            r_err_acc <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_z       <= '0;
            r_borrow  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_xs      <= bus.x;
                        r_ys      <= bus.y;
                        r_res     <= '0;
                        r_b       <= 1'b0;
                        r_err_acc <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_RUN;
                    end else begin
                        r_state   <= c_IDLE;
                    end
                end

                c_RUN: begin
                    r_xs      <= r_xs >> 4;
                    r_ys      <= r_ys >> 4;
                    r_res     <= w_res_next;
                    r_b       <= w_b_next;
                    r_err_acc <= w_err_next;
                    if (r_cnt == c_LAST) begin
                        // Publish on this edge only, so no partial result
                        // is visible during RUN.
                        r_state  <= c_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_z      <= w_err_next ? '0 : w_res_next;
                        r_borrow <= w_err_next ? 1'b0 : w_b_next;
                        r_err    <= w_err_next;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.z      = r_z;
    assign bus.borrow = r_borrow;
    assign bus.err    = r_err;

endmodule
`default_nettype wire
